// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode hazard controller.
package hazard_pkg;

  localparam int NREG_DEF  = 32;
  localparam int CNT_W_DEF = 2;
  localparam logic [4:0] X0 = 5'd0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register count of in-flight writes; x0 is never tracked.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG  = NREG_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            inc_en,
  input  logic [4:0]      inc_sel,
  input  logic            dec_en,
  input  logic [4:0]      dec_sel,
  output logic [NREG-1:0] busy_mask,
  output logic [NREG-1:0] sat_mask,
  output logic            underflow
);

  logic [CNT_W-1:0] pending [1:NREG-1];
  logic [NREG-1:1]  inc_vec;
  logic [NREG-1:1]  dec_vec;

  always_comb begin
    inc_vec   = '0;
    dec_vec   = '0;
    busy_mask = '0;
    sat_mask  = '0;
    for (int r = 1; r < NREG; r++) begin
      inc_vec[r]   = inc_en && (inc_sel == 5'(r));
      dec_vec[r]   = dec_en && (dec_sel == 5'(r));
      busy_mask[r] = (pending[r] != '0);
      sat_mask[r]  = &pending[r];
    end
  end

  // Simultaneous increment and decrement of one register cancel out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 1; r < NREG; r++) pending[r] <= '0;
      underflow <= 1'b0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (inc_vec[r] && !dec_vec[r])
          pending[r] <= pending[r] + CNT_W'(1);
        else if (dec_vec[r] && !inc_vec[r] && busy_mask[r])
          pending[r] <= pending[r] - CNT_W'(1);
      end
      if (dec_en && (dec_sel != X0) && !busy_mask[dec_sel])
        underflow <= 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage issue/stall/kill decision with scoreboard, FSM and perf counters.
// Build option: HAZ_FWD_EN selects load-use-only hazards (forwarding present).
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int NREG   = NREG_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int PERF_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dec_valid,
  input  logic [4:0]        dec_rs1,
  input  logic [4:0]        dec_rs2,
  input  logic              dec_use_rs1,
  input  logic              dec_use_rs2,
  input  logic [4:0]        dec_rd,
  input  logic              dec_is_wb,
  input  logic              dec_is_load,
  input  logic              br_en,
  input  logic              wb_en,
  input  logic [4:0]        wb_sel,
  output logic              stall,
  output logic              issue,
  output logic [NREG-1:0]   busy_mask,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count,
  output logic              err_underflow
);

  logic [NREG-1:0] sat_mask;
  logic            inc_en;
  logic            dec_en;
  logic            rs1_hz;
  logic            rs2_hz;
  logic            src_hz;
  logic            sat_hz;
  hz_state_e       state_q;
  hz_state_e       state_d;

  assign inc_en = issue && dec_is_wb && (dec_rd != X0);
  assign dec_en = wb_en && (wb_sel != X0);

  hazard_scoreboard #(
    .NREG  (NREG),
    .CNT_W (CNT_W)
  ) u_scoreboard (
    .clock     (clock),
    .reset     (reset),
    .inc_en    (inc_en),
    .inc_sel   (dec_rd),
    .dec_en    (dec_en),
    .dec_sel   (wb_sel),
    .busy_mask (busy_mask),
    .sat_mask  (sat_mask),
    .underflow (err_underflow)
  );

`ifdef HAZ_FWD_EN
  logic       last_load_vld;
  logic [4:0] last_load_rd;

  // Only a load issued last cycle can cause a source hazard; ALU results forward.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_load_vld <= 1'b0;
      last_load_rd  <= '0;
    end else begin
      last_load_vld <= issue && dec_is_load && dec_is_wb;
      last_load_rd  <= (issue && dec_is_load && dec_is_wb) ? dec_rd : '0;
    end
  end

  assign rs1_hz = last_load_vld && (last_load_rd == dec_rs1) && (dec_rs1 != X0);
  assign rs2_hz = last_load_vld && (last_load_rd == dec_rs2) && (dec_rs2 != X0);
`else
  logic unused_load;

  // Full interlock: wait for every producer to write back (bit 0 is never busy).
  assign rs1_hz      = busy_mask[dec_rs1];
  assign rs2_hz      = busy_mask[dec_rs2];
  assign unused_load = dec_is_load;
`endif

  assign src_hz = (dec_use_rs1 && rs1_hz) || (dec_use_rs2 && rs2_hz);
  assign sat_hz = dec_is_wb && (dec_rd != X0) && sat_mask[dec_rd];
  assign stall  = dec_valid && !br_en && (src_hz || sat_hz);
  assign issue  = dec_valid && !stall && !br_en;

  always_comb begin
    state_d = RUN;
    if (br_en)      state_d = FLUSH;
    else if (stall) state_d = STALL;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == STALL)
        stall_cycles <= stall_cycles + PERF_W'(1);
      if ((state_d == FLUSH) && dec_valid)
        flush_count <= flush_count + PERF_W'(1);
    end
  end

  a_no_stall_and_issue : assert property (@(posedge clock) disable iff (reset)
    !(stall && issue));
  a_no_count_overflow : assert property (@(posedge clock) disable iff (reset)
    inc_en |-> !sat_mask[dec_rd]);
  a_flush_follows_branch : assert property (@(posedge clock) disable iff (reset)
    (state_d == FLUSH) |-> br_en);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl against a spec-level reference model.
module tb_hazard_ctrl;

  localparam int NREG   = 32;
  localparam int CNT_W  = 2;
  localparam int PERF_W = 32;
  localparam int SATV   = (1 << CNT_W) - 1;

  logic              clock = 1'b0;
  logic              reset;
  logic              dec_valid;
  logic [4:0]        dec_rs1, dec_rs2, dec_rd, wb_sel;
  logic              dec_use_rs1, dec_use_rs2, dec_is_wb, dec_is_load;
  logic              br_en, wb_en;
  logic              stall, issue, err_underflow;
  logic [NREG-1:0]   busy_mask;
  logic [PERF_W-1:0] stall_cycles, flush_count;

  hazard_ctrl #(.NREG(NREG), .CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
    .clock         (clock),
    .reset         (reset),
    .dec_valid     (dec_valid),
    .dec_rs1       (dec_rs1),
    .dec_rs2       (dec_rs2),
    .dec_use_rs1   (dec_use_rs1),
    .dec_use_rs2   (dec_use_rs2),
    .dec_rd        (dec_rd),
    .dec_is_wb     (dec_is_wb),
    .dec_is_load   (dec_is_load),
    .br_en         (br_en),
    .wb_en         (wb_en),
    .wb_sel        (wb_sel),
    .stall         (stall),
    .issue         (issue),
    .busy_mask     (busy_mask),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count),
    .err_underflow (err_underflow)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          pend [NREG];
  bit          m_err;
  int unsigned m_stall, m_flush;
  bit          m_llv;
  int          m_llr;
  bit          exp_stall, exp_issue;
  logic [NREG-1:0] exp_busy;

  // Inputs of the current cycle, as seen by the model
  bit c_v, c_u1, c_u2, c_wb, c_ld, c_br, c_wbe;
  int c_rs1, c_rs2, c_rd, c_wbs;

  function automatic bit hz(input int r);
`ifdef HAZ_FWD_EN
    return (r != 0) && m_llv && (m_llr == r);
`else
    return (r != 0) && (pend[r] > 0);
`endif
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) pend[r] = 0;
    m_err = 0; m_stall = 0; m_flush = 0; m_llv = 0; m_llr = 0;
  endtask

  task automatic drive(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                       input int rd, input bit wb, input bit ld, input bit br,
                       input bit wbe, input int wbs);
    bit src, sat;
    c_v = v; c_rs1 = rs1; c_rs2 = rs2; c_u1 = u1; c_u2 = u2; c_rd = rd;
    c_wb = wb; c_ld = ld; c_br = br; c_wbe = wbe; c_wbs = wbs;
    dec_valid = v; dec_rs1 = 5'(rs1); dec_rs2 = 5'(rs2); dec_use_rs1 = u1; dec_use_rs2 = u2;
    dec_rd = 5'(rd); dec_is_wb = wb; dec_is_load = ld; br_en = br; wb_en = wbe; wb_sel = 5'(wbs);
    src = (u1 && hz(rs1)) || (u2 && hz(rs2));
    sat = wb && (rd != 0) && (pend[rd] == SATV);
    exp_stall = v && !br && (src || sat);
    exp_issue = v && !exp_stall && !br;
    exp_busy = '0;
    for (int r = 1; r < NREG; r++) exp_busy[r] = (pend[r] > 0);
    #1;
  endtask

  task automatic tick();
    bit inc, dec;
    @(posedge clock);
    inc = exp_issue && c_wb && (c_rd != 0);
    dec = c_wbe && (c_wbs != 0);
    if (dec && pend[c_wbs] == 0) m_err = 1;
    if (!(inc && dec && c_rd == c_wbs)) begin
      if (inc) pend[c_rd]++;
      if (dec && pend[c_wbs] > 0) pend[c_wbs]--;
    end
    if (exp_stall) m_stall++;
    if (c_br && c_v) m_flush++;
    m_llv = exp_issue && c_ld && c_wb;
    m_llr = m_llv ? c_rd : 0;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int r = 1; r < NREG; r++)
      for (int k = 0; k < SATV && pend[r] > 0; k++) begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, r);
        tick();
      end
    idle();
  endtask

  task automatic test_reset();
    drive(1, 3, 4, 1, 1, 6, 1, 0, 0, 0, 0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", stall); end
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL reset_issue: got %0b want 1", issue); end
    checks++; if (busy_mask !== '0) begin errors++; $display("FAIL reset_busy: got %h want 0", busy_mask); end
    checks++; if (stall_cycles !== '0) begin errors++; $display("FAIL reset_stall_cycles: got %0d want 0", stall_cycles); end
    checks++; if (flush_count !== '0) begin errors++; $display("FAIL reset_flush_count: got %0d want 0", flush_count); end
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", err_underflow); end
    idle();
  endtask

  task automatic test_interlock();
    int gap;
    gap = 0;
    drive(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0);
    checks++; if (issue !== exp_issue) begin errors++; $display("FAIL interlock_add_issue: got %0b want %0b", issue, exp_issue); end
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1, 5, 1, 1, 1, 6, 1, 0, 0, i == 3, 5);
      checks++; if (stall !== exp_stall) begin errors++; $display("FAIL interlock_stall c%0d: got %0b want %0b", i, stall, exp_stall); end
      checks++; if (issue !== exp_issue) begin errors++; $display("FAIL interlock_issue c%0d: got %0b want %0b", i, issue, exp_issue); end
      if (exp_stall) gap++;
      tick();
      if (exp_issue) break;
    end
    idle();
    checks++; if (stall_cycles !== m_stall) begin errors++; $display("FAIL interlock_stall_cycles: got %0d want %0d (gap %0d)", stall_cycles, m_stall, gap); end
`ifndef HAZ_FWD_EN
    checks++; if (gap != 4) begin errors++; $display("FAIL interlock_gap: got %0d want 4", gap); end
`endif
    drain();
  endtask

  task automatic test_load_use();
    drive(1, 1, 2, 1, 1, 7, 1, 1, 0, 0, 0);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(1, 7, 7, 1, 1, 8, 1, 0, 0, i == 2, 7);
      checks++; if (stall !== exp_stall) begin errors++; $display("FAIL loaduse_stall c%0d: got %0b want %0b", i, stall, exp_stall); end
      checks++; if (issue !== exp_issue) begin errors++; $display("FAIL loaduse_issue c%0d: got %0b want %0b", i, issue, exp_issue); end
      tick();
      if (exp_issue) break;
    end
    idle();
    drain();
    drive(1, 1, 2, 1, 1, 7, 1, 1, 0, 0, 0);
    tick();
    drive(1, 9, 9, 1, 1, 8, 1, 0, 0, 0, 0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL loaduse_indep_stall: got %0b want 0", stall); end
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL loaduse_indep_issue: got %0b want 1", issue); end
    tick();
    drain();
  endtask

  task automatic test_branch();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    tick();
    drive(1, 5, 5, 1, 1, 8, 1, 0, 1, 0, 0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL branch_stall: got %0b want 0", stall); end
    checks++; if (issue !== 1'b0) begin errors++; $display("FAIL branch_issue: got %0b want 0", issue); end
    tick();
    idle();
    checks++; if (flush_count !== m_flush) begin errors++; $display("FAIL branch_flush_count: got %0d want %0d", flush_count, m_flush); end
    checks++; if (busy_mask !== exp_busy) begin errors++; $display("FAIL branch_busy: got %h want %h", busy_mask, exp_busy); end
    drain();
  endtask

  task automatic test_same_cycle();
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 1, 3);
    tick();
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    checks++; if (busy_mask !== exp_busy) begin errors++; $display("FAIL same_cycle_busy: got %h want %h", busy_mask, exp_busy); end
    tick();
    idle();
    checks++; if (busy_mask !== exp_busy) begin errors++; $display("FAIL x0_busy: got %h want %h", busy_mask, exp_busy); end
    checks++; if (err_underflow !== m_err) begin errors++; $display("FAIL x0_err: got %0b want %0b", err_underflow, m_err); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
    tick();
    idle();
    checks++; if (busy_mask !== '0) begin errors++; $display("FAIL same_cycle_clear: got %h want 0", busy_mask); end
    drain();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < SATV; i++) begin
      drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0);
      tick();
    end
    drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 1, 4);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_stall: got %0b want 1", stall); end
    checks++; if (issue !== exp_issue) begin errors++; $display("FAIL sat_issue: got %0b want %0b", issue, exp_issue); end
    tick();
    drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0);
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL sat_release_issue: got %0b want 1", issue); end
    tick();
    drain();
  endtask

  task automatic test_underflow();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
    tick();
    idle();
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL underflow_set: got %0b want 1", err_underflow); end
    tick();
    tick();
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL underflow_sticky: got %0b want 1", err_underflow); end
    checks++; if (busy_mask[9] !== 1'b0) begin errors++; $display("FAIL underflow_count: got %0b want 0", busy_mask[9]); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      int wbs, start;
      bit wbe;
      wbe = ($urandom_range(0, 2) != 0);
      wbs = 0;
      if ($urandom_range(0, 7) == 0) wbs = $urandom_range(0, 31);
      else begin
        start = $urandom_range(1, 7);
        for (int k = 0; k < 7; k++)
          if (wbs == 0 && pend[((start + k - 1) % 7) + 1] > 0) wbs = ((start + k - 1) % 7) + 1;
        if (wbs == 0) wbe = 0;
      end
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 7) == 0, wbe, wbs);
      checks++; if (stall !== exp_stall) begin errors++; $display("FAIL rand_stall n%0d: got %0b want %0b", n, stall, exp_stall); end
      checks++; if (issue !== exp_issue) begin errors++; $display("FAIL rand_issue n%0d: got %0b want %0b", n, issue, exp_issue); end
      checks++; if (busy_mask !== exp_busy) begin errors++; $display("FAIL rand_busy n%0d: got %h want %h", n, busy_mask, exp_busy); end
      tick();
    end
    idle();
    checks++; if (stall_cycles !== m_stall) begin errors++; $display("FAIL rand_stall_cycles: got %0d want %0d", stall_cycles, m_stall); end
    checks++; if (flush_count !== m_flush) begin errors++; $display("FAIL rand_flush_count: got %0d want %0d", flush_count, m_flush); end
    checks++; if (err_underflow !== m_err) begin errors++; $display("FAIL rand_err: got %0b want %0b", err_underflow, m_err); end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
    tick();
    drive(1, 5, 0, 1, 0, 6, 1, 0, 0, 0, 0);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL midreset_pre_stall: got %0b want 1", stall); end
    #2 reset = 1'b1;
    #1;
    model_reset();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midreset_stall: got %0b want 0", stall); end
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL midreset_issue: got %0b want 1", issue); end
    checks++; if (busy_mask !== '0) begin errors++; $display("FAIL midreset_busy: got %h want 0", busy_mask); end
    checks++; if (stall_cycles !== '0) begin errors++; $display("FAIL midreset_stall_cycles: got %0d want 0", stall_cycles); end
    checks++; if (flush_count !== '0) begin errors++; $display("FAIL midreset_flush_count: got %0d want 0", flush_count); end
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL midreset_err: got %0b want 0", err_underflow); end
    @(posedge clock);
    #1 reset = 1'b0;
    idle();
  endtask

  initial begin
    reset = 1'b1;
    model_reset();
    idle();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    test_reset();
    test_interlock();
    test_load_use();
    test_branch();
    test_same_cycle();
    test_saturation();
    test_underflow();
    test_random();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
